spi_flash_seq: RTL and testbench
================================

Name: spi_flash_seq

Overview:
- Autonomous SPI-flash read sequencer that drives the NORA SPI master through its register port (CTRL/STAT/DATA selects, wr/rd strobes, 8-bit data).
- Issues READ (0x03) + 24-bit address, then streams N bytes out over a valid/ready byte port.
- Also arbitrates the SPI master register port between the CPU path (from the system register block) and the sequencer. CPU owns the port only while the sequencer is idle.

Parameters:
- CMD_READ, 8'h03, flash read opcode.
- CLKDIV, 3'd0, SPI clock divider written into CTRL[2:0] at select.
- LEN_W, 16, width of the byte-count input.

Ports:
- clk  in  1  48MHz system clock
- resetn  in  1  synchronous reset, active-low
- start_i  in  1  1-cycle pulse; latches addr_i/len_i when idle
- addr_i  in  24  flash start address
- len_i  in  LEN_W  byte count; 0 = no transfer
- abort_i  in  1  terminate current transfer
- busy_o  out  1  sequencer owns SPI port
- done_o  out  1  1-cycle pulse at end of transfer (normal or abort)
- byte_o  out  8  received byte
- byte_valid_o  out  1  byte_o valid
- byte_ready_i  in  1  consumer accepts byte
- cpu_d_i  in  8  CPU write data
- cpu_wr_i, cpu_rd_i  in  1  CPU register strobes
- cpu_cs_ctrl_i, cpu_cs_stat_i, cpu_cs_data_i  in  1  CPU register selects
- cpu_d_o  out  8  CPU read data
- cpu_blocked_o  out  1  CPU access was dropped this cycle
- spi_d_o  out  8  data to SPI master
- spi_d_i  in  8  data from SPI master; combinational for the selected register
- spi_wr_o, spi_rd_o  out  1  SPI master strobes
- spi_cs_ctrl_o, spi_cs_stat_o, spi_cs_data_o  out  1  SPI master register selects

Behaviour:
- SPI master register map:
  - CTRL write: [3] = CS assert, [2:0] = divider.
  - STAT read: [7] = busy.
  - DATA write: starts an 8-bit exchange.
  - DATA read: returns the last received byte.
- Reset: FSM = IDLE.
  - busy_o, done_o, byte_valid_o, cpu_blocked_o = 0; byte_o = 8'h00.
  - All spi_* strobes and selects = 0; spi_d_o = 8'h00.
- Arbitration:
  - IDLE: CPU signals pass combinationally to spi_*, and cpu_d_o = spi_d_i.
  - Any other state: spi_* is driven by the FSM only.
  - CPU wr/rd during non-IDLE is dropped, with cpu_d_o = 8'h00 and cpu_blocked_o = 1 in that same cycle.
- Register access (FSM): a single-cycle strobe with exactly one select. On a read, spi_d_i is sampled in the strobe cycle.
- FSM states:
  - IDLE: on start_i with len_i != 0, latch addr/len into cnt → SEL, busy_o = 1. start_i with len_i == 0 → done_o pulse, stay IDLE.
  - SEL: write CTRL = {4'b0, 1, CLKDIV} → CMD.
  - CMD / A2 / A1 / A0: write DATA = CMD_READ, addr[23:16], addr[15:8], addr[7:0]; each goes to WAITx.
  - WAITx: read STAT every cycle until [7] = 0, then advance to the next byte state.
  - A0's wait goes to XFER.
  - XFER: write DATA = 8'h00 (dummy) → WAITD.
  - WAITD: poll STAT until [7] = 0 → RDD.
  - RDD: read DATA, byte_o <= spi_d_i, byte_valid_o <= 1 → OUT.
  - OUT: hold until byte_valid_o && byte_ready_i. On handshake: clear valid, cnt <= cnt - 1. Then cnt == 1 (pre-decrement) → DESEL, else → XFER.
  - DESEL: write CTRL = {4'b0, 0, CLKDIV} → IDLE, with done_o = 1 for one cycle and busy_o = 0 from the next cycle.
- Throughput: never launch the next dummy byte until the previous byte has been accepted (single-byte buffer, no overrun).
- start_i while busy: ignored.
- abort_i in any non-IDLE state:
  - byte_valid_o cleared.
  - If a SPI exchange is in flight (WAIT* states), finish polling until not busy first, then DESEL.
  - Otherwise go to DESEL next cycle.
  - done_o pulses at the DESEL exit.
- abort_i in IDLE: no effect.
- Address: 24-bit, no internal increment needed (flash auto-increments). A wrap past 0xFFFFFF is the flash's concern.
- Reset mid-transfer: FSM to IDLE immediately. No DESEL write is issued; the SPI master's own reset deasserts CS.

Decomposition:
- Shared package holds:
  - SPI register bit positions: CTRL_CS = 3, CTRL_DIV = [2:0], STAT_BUSY = 7.
  - FSM state encoding.
  - The CMD_READ default.
- No sub-module; the CPU/FSM mux is a small always-block inside the module.

Test Plan:
- Reset mid-XFER → next cycle FSM IDLE, busy_o = 0, all strobes 0, CPU pass-through live.
- Basic read: start addr = 0x123456, len = 3; SPI model returns 0xA1, 0xB2, 0xC3, busy for 5 cycles per byte.
  - Required DATA write sequence: 0x03, 0x12, 0x34, 0x56, 0x00 ×3.
  - CTRL written 0x08 then 0x00.
  - Bytes out A1, B2, C3; one done_o pulse.
- Backpressure: byte_ready_i low for 20 cycles on byte 2 → byte_o held stable, no DATA write during the stall, byte count still 3.
- CPU contention: CPU writes DATA = 0x9F during the transfer → dropped, cpu_blocked_o = 1 that cycle, no spi_wr_o from the CPU. The same write while IDLE → passes through the same cycle.
- Abort: abort_i during the A1 wait → polling finishes, CTRL 0x00 written, done_o pulses, no byte_valid_o seen.
- len = 0 → done_o pulse the cycle after start, zero SPI accesses, busy_o stays 0.

Source files
------------

// File: rtl/spi_flash_seq_pkg.sv
// spi_flash_seq shared definitions
// SPI master register fields, FSM states, request bundle
package spi_flash_seq_pkg;

  localparam int CTRL_CS     = 3;
  localparam int CTRL_DIV_HI = 2;
  localparam int CTRL_DIV_LO = 0;
  localparam int STAT_BUSY   = 7;

  localparam logic [7:0] CMD_READ_DEF = 8'h03;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEL,
    S_CMD,
    S_WCMD,
    S_A2,
    S_WA2,
    S_A1,
    S_WA1,
    S_A0,
    S_WA0,
    S_XFER,
    S_WAITD,
    S_RDD,
    S_OUT,
    S_DESEL
  } state_t;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       cs_ctrl;
    logic       cs_stat;
    logic       cs_data;
    logic [7:0] d;
  } spi_req_t;

  function automatic spi_req_t wr_ctrl(
    input logic       cs,
    input logic [2:0] div
  );
    spi_req_t r;
    r = '0;
    r.wr = 1'b1;
    r.cs_ctrl = 1'b1;
    r.d[CTRL_CS] = cs;
    r.d[CTRL_DIV_HI:CTRL_DIV_LO] = div;
    return r;
  endfunction

  function automatic spi_req_t wr_data(
    input logic [7:0] d
  );
    spi_req_t r;
    r = '0;
    r.wr = 1'b1;
    r.cs_data = 1'b1;
    r.d = d;
    return r;
  endfunction

  function automatic spi_req_t rd_stat();
    spi_req_t r;
    r = '0;
    r.rd = 1'b1;
    r.cs_stat = 1'b1;
    return r;
  endfunction

  function automatic spi_req_t rd_data();
    spi_req_t r;
    r = '0;
    r.rd = 1'b1;
    r.cs_data = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: autonomous SPI-flash READ sequencer
// Shares the SPI master register port with the CPU path
module spi_flash_seq
  import spi_flash_seq_pkg::*;
#(
  parameter logic [7:0] CMD_READ = CMD_READ_DEF,
  parameter logic [2:0] CLKDIV   = 3'd0,
  parameter int         LEN_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  input  logic [7:0]       cpu_d_i,
  input  logic             cpu_wr_i,
  input  logic             cpu_rd_i,
  input  logic             cpu_cs_ctrl_i,
  input  logic             cpu_cs_stat_i,
  input  logic             cpu_cs_data_i,
  output logic [7:0]       cpu_d_o,
  output logic             cpu_blocked_o,
  output logic [7:0]       spi_d_o,
  input  logic [7:0]       spi_d_i,
  output logic             spi_wr_o,
  output logic             spi_rd_o,
  output logic             spi_cs_ctrl_o,
  output logic             spi_cs_stat_o,
  output logic             spi_cs_data_o
);

  state_t           state;
  spi_req_t         req;
  logic [23:0]      addr;
  logic [LEN_W-1:0] cnt;
  logic             abt;
  logic             stop;
  logic             sbusy;

  assign stop  = abort_i | abt;
  assign sbusy = spi_d_i[STAT_BUSY];

  // Sequencer FSM; req holds the strobe for the state being entered
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      req          <= '0;
      addr         <= '0;
      cnt          <= '0;
      abt          <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
    end else begin
      req    <= '0;
      done_o <= 1'b0;
      if (state != S_IDLE && abort_i) begin
        abt          <= 1'b1;
        byte_valid_o <= 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          abt <= 1'b0;
          if (start_i) begin
            if (len_i != '0) begin
              addr   <= addr_i;
              cnt    <= len_i;
              busy_o <= 1'b1;
              req    <= wr_ctrl(1'b1, CLKDIV);
              state  <= S_SEL;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        S_SEL: begin
          if (abort_i) begin
            req   <= wr_ctrl(1'b0, CLKDIV);
            state <= S_DESEL;
          end else begin
            req   <= wr_data(CMD_READ);
            state <= S_CMD;
          end
        end
        S_CMD, S_A2, S_A1, S_A0, S_XFER: begin
          if (abort_i) begin
            req   <= wr_ctrl(1'b0, CLKDIV);
            state <= S_DESEL;
          end else begin
            req <= rd_stat();
            unique case (state)
              S_CMD:   state <= S_WCMD;
              S_A2:    state <= S_WA2;
              S_A1:    state <= S_WA1;
              S_A0:    state <= S_WA0;
              default: state <= S_WAITD;
            endcase
          end
        end
        S_WCMD, S_WA2, S_WA1, S_WA0, S_WAITD: begin
          if (sbusy) begin
            req <= rd_stat();
          end else if (stop) begin
            req   <= wr_ctrl(1'b0, CLKDIV);
            state <= S_DESEL;
          end else begin
            unique case (state)
              S_WCMD: begin
                req   <= wr_data(addr[23:16]);
                state <= S_A2;
              end
              S_WA2: begin
                req   <= wr_data(addr[15:8]);
                state <= S_A1;
              end
              S_WA1: begin
                req   <= wr_data(addr[7:0]);
                state <= S_A0;
              end
              S_WA0: begin
                req   <= wr_data(8'h00);
                state <= S_XFER;
              end
              default: begin
                req   <= rd_data();
                state <= S_RDD;
              end
            endcase
          end
        end
        S_RDD: begin
          if (abort_i) begin
            req   <= wr_ctrl(1'b0, CLKDIV);
            state <= S_DESEL;
          end else begin
            byte_o       <= spi_d_i;
            byte_valid_o <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          if (abort_i) begin
            req   <= wr_ctrl(1'b0, CLKDIV);
            state <= S_DESEL;
          end else if (byte_ready_i) begin
            byte_valid_o <= 1'b0;
            cnt          <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              req   <= wr_ctrl(1'b0, CLKDIV);
              state <= S_DESEL;
            end else begin
              req   <= wr_data(8'h00);
              state <= S_XFER;
            end
          end
        end
        S_DESEL: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Port mux: CPU passes through only while the sequencer is idle
  always_comb begin
    spi_wr_o      = req.wr;
    spi_rd_o      = req.rd;
    spi_cs_ctrl_o = req.cs_ctrl;
    spi_cs_stat_o = req.cs_stat;
    spi_cs_data_o = req.cs_data;
    spi_d_o       = req.d;
    cpu_d_o       = 8'h00;
    cpu_blocked_o = 1'b0;
    if (state == S_IDLE) begin
      spi_wr_o      = cpu_wr_i;
      spi_rd_o      = cpu_rd_i;
      spi_cs_ctrl_o = cpu_cs_ctrl_i;
      spi_cs_stat_o = cpu_cs_stat_i;
      spi_cs_data_o = cpu_cs_data_i;
      spi_d_o       = cpu_d_i;
      cpu_d_o       = spi_d_i;
    end else begin
      cpu_blocked_o = cpu_wr_i | cpu_rd_i;
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: directed bench for spi_flash_seq
// Includes a small SPI master register model
module tb_spi_flash_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [23:0] addr_i;
  logic [15:0] len_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic [7:0]  cpu_d_i;
  logic        cpu_wr_i;
  logic        cpu_rd_i;
  logic        cpu_cs_ctrl_i;
  logic        cpu_cs_stat_i;
  logic        cpu_cs_data_i;
  logic [7:0]  cpu_d_o;
  logic        cpu_blocked_o;
  logic [7:0]  spi_d_o;
  logic [7:0]  spi_d_i;
  logic        spi_wr_o;
  logic        spi_rd_o;
  logic        spi_cs_ctrl_o;
  logic        spi_cs_stat_o;
  logic        spi_cs_data_o;

  always #5 clk = ~clk;

  spi_flash_seq dut (
    .clk           (clk),
    .resetn        (resetn),
    .start_i       (start_i),
    .addr_i        (addr_i),
    .len_i         (len_i),
    .abort_i       (abort_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .byte_o        (byte_o),
    .byte_valid_o  (byte_valid_o),
    .byte_ready_i  (byte_ready_i),
    .cpu_d_i       (cpu_d_i),
    .cpu_wr_i      (cpu_wr_i),
    .cpu_rd_i      (cpu_rd_i),
    .cpu_cs_ctrl_i (cpu_cs_ctrl_i),
    .cpu_cs_stat_i (cpu_cs_stat_i),
    .cpu_cs_data_i (cpu_cs_data_i),
    .cpu_d_o       (cpu_d_o),
    .cpu_blocked_o (cpu_blocked_o),
    .spi_d_o       (spi_d_o),
    .spi_d_i       (spi_d_i),
    .spi_wr_o      (spi_wr_o),
    .spi_rd_o      (spi_rd_o),
    .spi_cs_ctrl_o (spi_cs_ctrl_o),
    .spi_cs_stat_o (spi_cs_stat_o),
    .spi_cs_data_o (spi_cs_data_o)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // SPI master model: 5 busy cycles per DATA write
  logic [3:0] bcnt = '0;
  logic [7:0] rx = 8'h00;
  logic [7:0] resp [8];
  logic [7:0] wlog [16];
  logic [7:0] clog [8];
  logic [7:0] blog [8];
  int nd, nc, nacc, nb, nvalid, ndone, ovr, n9f, cbusy;
  int clr_gen = 0;
  int seen_gen = 0;

  assign spi_d_i = spi_cs_stat_o ? {(bcnt != 4'd0), 7'b0} :
                   spi_cs_data_o ? rx : 8'h00;

  always @(posedge clk) begin
    if (seen_gen != clr_gen) begin
      seen_gen = clr_gen;
      nd = 0; nc = 0; nacc = 0; nb = 0; nvalid = 0;
      ndone = 0; ovr = 0; n9f = 0; cbusy = 0;
    end
    if (spi_wr_o && spi_cs_data_o) begin
      if (nd < 16) wlog[nd] = spi_d_o;
      if (nd >= 4 && nd < 12) rx <= resp[nd-4];
      else rx <= 8'hFF;
      if (byte_valid_o) ovr++;
      if (spi_d_o == 8'h9F) n9f++;
      nd++;
      bcnt <= 4'd5;
    end else if (bcnt != 4'd0) begin
      bcnt <= bcnt - 4'd1;
    end
    if (spi_wr_o && spi_cs_ctrl_o) begin
      if (nc < 8) clog[nc] = spi_d_o;
      if (bcnt != 4'd0) cbusy++;
      nc++;
    end
    if (spi_wr_o || spi_rd_o) nacc++;
    if (byte_valid_o) nvalid++;
    if (byte_valid_o && byte_ready_i) begin
      if (nb < 8) blog[nb] = byte_o;
      nb++;
    end
    if (done_o) ndone++;
  end

  task automatic clr();
    clr_gen++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run(
    input logic [23:0] a,
    input logic [15:0] n,
    input int          stall_at,
    input int          stall_n,
    input logic [7:0]  hold_exp,
    input int          poke
  );
    int held;
    int cyc;
    bit fin;
    held = 0;
    cyc = 0;
    fin = 1'b0;
    @(negedge clk);
    addr_i = a;
    len_i = n;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cpu_wr_i = 1'b0;
      cpu_cs_data_i = 1'b0;
      if (byte_valid_o && nb == stall_at && held < stall_n) begin
        byte_ready_i = 1'b0;
        held++;
        if (held == stall_n) chk("hold", byte_o, hold_exp);
      end else begin
        byte_ready_i = 1'b1;
      end
      if (cyc == poke) begin
        cpu_d_i = 8'h9F;
        cpu_wr_i = 1'b1;
        cpu_cs_data_i = 1'b1;
        #1;
        chk("cpu_blk", cpu_blocked_o, 1);
        chk("cpu_d_blk", cpu_d_o, 8'h00);
      end
      if (ndone != 0) fin = 1'b1;
    end
    cpu_wr_i = 1'b0;
    cpu_cs_data_i = 1'b0;
    byte_ready_i = 1'b1;
    chk("run_tmo", fin, 1);
    idle(3);
    chk("run_busy", busy_o, 0);
    chk("run_done", ndone, 1);
  endtask

  logic [7:0] exp_w [7];
  int cyc;

  initial begin
    resetn = 1'b0;
    start_i = 1'b0;
    addr_i = '0;
    len_i = '0;
    abort_i = 1'b0;
    byte_ready_i = 1'b1;
    cpu_d_i = 8'h00;
    cpu_wr_i = 1'b0;
    cpu_rd_i = 1'b0;
    cpu_cs_ctrl_i = 1'b0;
    cpu_cs_stat_i = 1'b0;
    cpu_cs_data_i = 1'b0;
    resp[0] = 8'hA1; resp[1] = 8'hB2; resp[2] = 8'hC3; resp[3] = 8'hD4;
    resp[4] = 8'hE5; resp[5] = 8'hF6; resp[6] = 8'h07; resp[7] = 8'h18;
    exp_w[0] = 8'h03; exp_w[1] = 8'h12; exp_w[2] = 8'h34;
    exp_w[3] = 8'h56; exp_w[4] = 8'h00; exp_w[5] = 8'h00;
    exp_w[6] = 8'h00;

    idle(3);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", byte_valid_o, 0);
    chk("rst_byte", byte_o, 8'h00);
    chk("rst_blk", cpu_blocked_o, 0);
    chk("rst_strb", {spi_wr_o, spi_rd_o, spi_cs_ctrl_o,
                     spi_cs_stat_o, spi_cs_data_o}, 0);
    chk("rst_d", spi_d_o, 8'h00);

    // basic read
    clr();
    run(24'h123456, 16'd3, -1, 0, 8'h00, -1);
    chk("b_nd", nd, 7);
    for (int i = 0; i < 7; i++) chk($sformatf("b_w%0d", i), wlog[i], exp_w[i]);
    chk("b_nc", nc, 2);
    chk("b_c0", clog[0], 8'h08);
    chk("b_c1", clog[1], 8'h00);
    chk("b_nb", nb, 3);
    chk("b_y0", blog[0], 8'hA1);
    chk("b_y1", blog[1], 8'hB2);
    chk("b_y2", blog[2], 8'hC3);
    chk("b_ovr", ovr, 0);

    // backpressure on byte 2 plus CPU write while busy
    clr();
    run(24'h123456, 16'd3, 1, 20, 8'hB2, 15);
    chk("bp_nb", nb, 3);
    chk("bp_y1", blog[1], 8'hB2);
    chk("bp_nd", nd, 7);
    chk("bp_ovr", ovr, 0);
    chk("bp_9f", n9f, 0);

    // CPU write while idle passes straight through
    @(negedge clk);
    cpu_d_i = 8'h9F;
    cpu_wr_i = 1'b1;
    cpu_cs_data_i = 1'b1;
    #1;
    chk("ci_wr", spi_wr_o, 1);
    chk("ci_sel", spi_cs_data_o, 1);
    chk("ci_d", spi_d_o, 8'h9F);
    chk("ci_blk", cpu_blocked_o, 0);
    @(negedge clk);
    cpu_wr_i = 1'b0;
    cpu_cs_data_i = 1'b0;
    cpu_d_i = 8'h00;
    idle(10);

    // abort during the A1 wait
    clr();
    @(negedge clk);
    addr_i = 24'hABCDEF;
    len_i = 16'd2;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (nd < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("ab_reach", nd, 3);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    cyc = 0;
    while (ndone == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("ab_tmo", ndone, 1);
    idle(3);
    chk("ab_nd", nd, 3);
    chk("ab_nc", nc, 2);
    chk("ab_c1", clog[1], 8'h00);
    chk("ab_cbusy", cbusy, 0);
    chk("ab_valid", nvalid, 0);
    chk("ab_done", ndone, 1);
    chk("ab_busy", busy_o, 0);
    idle(10);

    // zero-length start
    clr();
    @(negedge clk);
    len_i = 16'd0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("z_done", done_o, 1);
    chk("z_busy", busy_o, 0);
    @(negedge clk);
    chk("z_done2", done_o, 0);
    idle(5);
    chk("z_acc", nacc, 0);
    chk("z_ndone", ndone, 1);

    // reset mid-transfer
    clr();
    @(negedge clk);
    addr_i = 24'h123456;
    len_i = 16'd3;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (nd < 5 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("r_reach", nd, 5);
    resetn = 1'b0;
    @(negedge clk);
    chk("r_busy", busy_o, 0);
    chk("r_valid", byte_valid_o, 0);
    chk("r_strb", {spi_wr_o, spi_rd_o, spi_cs_ctrl_o,
                   spi_cs_stat_o, spi_cs_data_o}, 0);
    cpu_rd_i = 1'b1;
    cpu_cs_stat_i = 1'b1;
    #1;
    chk("r_cpu_rd", spi_rd_o, 1);
    chk("r_cpu_sel", spi_cs_stat_o, 1);
    chk("r_cpu_d", cpu_d_o, 8'h80);
    chk("r_cpu_blk", cpu_blocked_o, 0);
    @(negedge clk);
    cpu_rd_i = 1'b0;
    cpu_cs_stat_i = 1'b0;
    resetn = 1'b1;
    idle(3);
    chk("r_busy2", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
